// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared arbiter types, limits and the one-hot to index helper
package arb_pkg;
  localparam int MAX_N = 32;
  localparam int MAX_IW = $clog2(MAX_N);
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) onehot_to_idx = onehot_to_idx | MAX_IW'(i);
  endfunction
endpackage

// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter_if #(parameter int N = 8);
  localparam int IW = $clog2(N);
  logic [N-1:0] REQ;
  logic LAST;
  logic [N-1:0] GNT;
  logic GNT_VALID;
  logic [IW-1:0] GNT_IDX;
  modport master(output REQ, LAST, input GNT, GNT_VALID, GNT_IDX);
  modport slave(input REQ, LAST, output GNT, GNT_VALID, GNT_IDX);
endinterface

// File: rtl/rr_arbiter_lsb_isolate.sv
// lsb_isolate: keeps only the lowest set bit of x and flags a non-zero input
module lsb_isolate #(parameter int W = 8) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         nz
);
  assign y = x & ~(x - W'(1));
  assign nz = |x;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant and optional lock
module rr_arbiter import arb_pkg::*; #(
  parameter int N = 8,
  parameter bit LOCK = 1'b1,
  localparam int IW = $clog2(N)
) (
  input logic CLK,
  input logic ASYNCRESETN,
  rr_arbiter_if.slave bus
);
  state_t state;
  logic [IW-1:0] ptr, pickIdx, nextPtr;
  logic [N-1:0] mask, maskedPick, plainPick, pick;
  logic maskedAny, plainAny, hold;
  // requesters at or above the pointer form the high-priority window
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = i >= int'(ptr);
  end
  lsb_isolate #(.W(N)) uMasked (.x(bus.REQ & mask), .y(maskedPick), .nz(maskedAny));
  lsb_isolate #(.W(N)) uPlain (.x(bus.REQ), .y(plainPick), .nz(plainAny));
  assign pick = maskedAny ? maskedPick : plainPick;
  assign pickIdx = IW'(onehot_to_idx(MAX_N'(pick)));
  assign nextPtr = pickIdx == IW'(N - 1) ? '0 : pickIdx + IW'(1);
  assign hold = LOCK && state == BUSY && |(bus.REQ & bus.GNT) && !bus.LAST;
  // grant FSM: hold a locked grant, otherwise re-arbitrate every cycle
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      ptr <= '0;
      bus.GNT <= '0;
      bus.GNT_VALID <= 1'b0;
      bus.GNT_IDX <= '0;
    end else if (!hold) begin
      state <= plainAny ? BUSY : IDLE;
      ptr <= plainAny ? nextPtr : ptr;
      bus.GNT <= plainAny ? pick : '0;
      bus.GNT_VALID <= plainAny;
      bus.GNT_IDX <= plainAny ? pickIdx : '0;
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of an N=8 locking and an N=5 non-locking arbiter
module tb_rr_arbiter;
  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  int checks = 0;
  int failures = 0;
  rr_arbiter_if #(.N(8)) aIf();
  rr_arbiter_if #(.N(5)) bIf();
  rr_arbiter #(.N(8), .LOCK(1'b1)) uA (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(aIf.slave));
  rr_arbiter #(.N(5), .LOCK(1'b0)) uB (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bIf.slave));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic expA(input string tag, input logic [7:0] g, input logic [2:0] i);
    check({tag, ".gnt"}, 32'(aIf.GNT), 32'(g));
    check({tag, ".valid"}, 32'(aIf.GNT_VALID), 32'(g != 8'h00));
    check({tag, ".idx"}, 32'(aIf.GNT_IDX), 32'(i));
  endtask
  task automatic drive(input logic [7:0] r, input logic l);
    aIf.REQ = r;
    aIf.LAST = l;
  endtask
  task automatic doReset();
    ASYNCRESETN = 1'b0;
    step();
    ASYNCRESETN = 1'b1;
  endtask
  initial begin
    bIf.REQ = '0;
    bIf.LAST = 1'b0;
    drive(8'hFF, 1'b1);
    step();
    step();
    expA("rst_hold", 8'h00, 3'd0);
    check("rst_hold.b", 32'(bIf.GNT), 32'h0);
    ASYNCRESETN = 1'b1;
    drive(8'h01, 1'b1);
    step();
    expA("single", 8'h01, 3'd0);
    drive(8'h00, 1'b1);
    step();
    expA("single_idle", 8'h00, 3'd0);
    doReset();
    drive(8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      expA($sformatf("rot%0d", k), 8'(1 << (k % 8)), 3'(k % 8));
    end
    drive(8'h20, 1'b1);
    step();
    expA("grant5", 8'h20, 3'd5);
    drive(8'h21, 1'b1);
    step();
    expA("wrap", 8'h01, 3'd0);
    drive(8'h04, 1'b1);
    step();
    expA("lock_take", 8'h04, 3'd2);
    drive(8'h0C, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      expA($sformatf("lock_hold%0d", k), 8'h04, 3'd2);
    end
    drive(8'h0C, 1'b1);
    step();
    expA("lock_last", 8'h08, 3'd3);
    drive(8'h04, 1'b1);
    step();
    expA("lock_take2", 8'h04, 3'd2);
    drive(8'h0C, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      expA($sformatf("lock_hold2_%0d", k), 8'h04, 3'd2);
    end
    drive(8'h08, 1'b0);
    step();
    expA("lock_drop", 8'h08, 3'd3);
    drive(8'h00, 1'b1);
    step();
    expA("to_idle", 8'h00, 3'd0);
    drive(8'h11, 1'b0);
    step();
    expA("ptr_kept", 8'h10, 3'd4);
    drive(8'h10, 1'b1);
    step();
    expA("regrant", 8'h10, 3'd4);
    drive(8'h18, 1'b0);
    ASYNCRESETN = 1'b0;
    #2;
    expA("async_rst", 8'h00, 3'd0);
    #4;
    ASYNCRESETN = 1'b1;
    step();
    expA("post_rst", 8'h08, 3'd3);
    drive(8'h00, 1'b0);
    doReset();
    bIf.REQ = 5'h1F;
    bIf.LAST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("n5_gnt%0d", k), 32'(bIf.GNT), 32'(1 << (k % 5)));
      check($sformatf("n5_idx%0d", k), 32'(bIf.GNT_IDX), 32'(k % 5));
      check($sformatf("n5_valid%0d", k), 32'(bIf.GNT_VALID), 32'h1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
